// File: rtl/ei_divider.sv
// ei_divider: sequential unsigned restoring divider.
// Produces one quotient bit per enabled cycle. Handshake is start/busy/done,
// and the en input stalls every register in the block.
module ei_divider #(
    parameter int unsigned DVD_W = 16,
    parameter int unsigned DVS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] q_out,
    output logic [DVS_W-1:0] r_out,
    output logic             div_zero
);

    localparam int unsigned    CNT_W = $clog2(DVD_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DVD_W - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Working registers
    logic [DVS_W:0]   rem;
    logic [DVD_W-1:0] shreg;
    logic [DVS_W-1:0] dvs;
    logic [CNT_W-1:0] cnt;

    // Combinational step results and control decodes
    logic [DVS_W:0]   trial;
    logic             ge;
    logic [DVS_W:0]   rem_nxt;
    logic [DVD_W-1:0] shreg_nxt;
    logic             accept_idle;
    logic             zero_req;
    logic             last_step;
    logic             chain;
    logic             load;

    assign busy = (state == RUN);

    // Next-state logic and one restoring-division step
    always_comb begin
        state_nxt   = state;
        trial       = {rem[DVS_W-1:0], shreg[DVD_W-1]};
        // rem[DVS_W] is always 0 while rem < dvs holds, but folding it into
        // the compare keeps the step correct for the full register width.
        ge          = rem[DVS_W] | (trial >= {1'b0, dvs});
        rem_nxt     = ge ? (trial - {1'b0, dvs}) : trial;
        shreg_nxt   = {shreg[DVD_W-2:0], ge};
        accept_idle = (state == IDLE) && start && (divisor != '0);
        zero_req    = (state == IDLE) && start && (divisor == '0);
        last_step   = (state == RUN) && (cnt == LAST);
        // A start on the completion edge is chained straight into a new run.
        // A zero divisor there is dropped: the completing result owns done.
        chain       = last_step && start && (divisor != '0);
        load        = accept_idle || chain;

        case (state)
            IDLE: begin
                if (accept_idle) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step && !chain) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Working registers: load on accept, shift/subtract while running
    always_ff @(posedge clk) begin
        if (rst) begin
            rem   <= '0;
            shreg <= '0;
            dvs   <= '0;
            cnt   <= '0;
        end else if (en) begin
            if (load) begin
                rem   <= '0;
                shreg <= dividend;
                dvs   <= divisor;
                cnt   <= '0;
            end else if (state == RUN) begin
                rem   <= rem_nxt;
                shreg <= shreg_nxt;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

    // Result registers and the one-cycle done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            q_out    <= '0;
            r_out    <= '0;
            div_zero <= 1'b0;
        end else if (en) begin
            done <= 1'b0;
            if (last_step) begin
                q_out    <= shreg_nxt;
                r_out    <= rem_nxt[DVS_W-1:0];
                div_zero <= 1'b0;
                done     <= 1'b1;
            end else if (zero_req) begin
                q_out    <= '1;
                r_out    <= dividend[DVS_W-1:0];
                div_zero <= 1'b1;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ei_divider.sv
// tb_ei_divider: directed scenarios plus randomized operations for ei_divider,
// checked against plain integer division in the bench.
module tb_ei_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] q_out;
    logic [7:0]  r_out;
    logic        div_zero;

    int n_assert = 0;
    int n_fail   = 0;

    ei_divider #(.DVD_W(16), .DVS_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .q_out    (q_out),
        .r_out    (r_out),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step until done is seen or the budget runs out; n = edges taken
    task automatic wait_done(input int limit, output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (!got && n < limit) begin
            step();
            n++;
            if (done) got = 1'b1;
        end
    endtask

    // Full operation with en held high; expectations supplied by the caller
    task automatic do_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er);
        int  n;
        bit  got;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start = 1'b0;
        wait_done(40, n, got);
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'd16);
        chk({tag, "_q"}, 32'(q_out), 32'(eq));
        chk({tag, "_r"}, 32'(r_out), 32'(er));
        chk({tag, "_dz"}, 32'(div_zero), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    // Random operation with random stalls, checked against integer division
    task automatic run_rand();
        logic [15:0] a;
        logic [7:0]  b;
        int          hi;
        int          c;
        bit          got;
        a = 16'($urandom);
        case ($urandom_range(0, 15))
            0:       b = 8'd0;
            1, 2:    b = 8'($urandom_range(1, 3));
            3:       b = 8'hFF;
            default: b = 8'($urandom);
        endcase
        dividend = a;
        divisor  = b;
        en       = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        if (b == 8'd0) begin
            chk("rnd_z_done", 32'(done), 32'd1);
            chk("rnd_z_q", 32'(q_out), 32'hFFFF);
            chk("rnd_z_r", 32'(r_out), 32'(a[7:0]));
            chk("rnd_z_dz", 32'(div_zero), 32'd1);
            chk("rnd_z_busy", 32'(busy), 32'd0);
        end else begin
            hi  = 0;
            got = 1'b0;
            c   = 0;
            while (!got && c < 200) begin
                en = ($urandom_range(0, 9) != 0);
                step();
                if (en) hi++;
                if (done) got = 1'b1;
                c++;
            end
            en = 1'b1;
            chk("rnd_done_seen", 32'(got), 32'd1);
            chk("rnd_active_edges", 32'(hi), 32'd16);
            chk("rnd_q", 32'(q_out), 32'(a / b));
            chk("rnd_r", 32'(r_out), 32'(a % b));
            chk("rnd_dz", 32'(div_zero), 32'd0);
            chk("rnd_invariant", 32'(q_out) * 32'(b) + 32'(r_out), 32'(a));
            chk("rnd_r_lt_d", 32'(r_out < b), 32'd1);
        end
    endtask

    initial begin
        int  n;
        bit  got;
        bit  seen;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(q_out), 32'd0);
        chk("rst_r", 32'(r_out), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        rst = 1'b0;
        step();

        // 100 / 7 with cycle-exact busy/done profile
        dividend = 16'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        step();
        start = 1'b0;
        chk("d100_busy_c1", 32'(busy), 32'd1);
        chk("d100_done_c1", 32'(done), 32'd0);
        seen = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            step();
            if (!busy || done) seen = 1'b1;
        end
        chk("d100_busy_profile", 32'(seen), 32'd0);
        step();
        chk("d100_done", 32'(done), 32'd1);
        chk("d100_busy_off", 32'(busy), 32'd0);
        chk("d100_q", 32'(q_out), 32'd14);
        chk("d100_r", 32'(r_out), 32'd2);
        chk("d100_dz", 32'(div_zero), 32'd0);
        step();
        chk("d100_done_pulse", 32'(done), 32'd0);
        chk("d100_q_hold", 32'(q_out), 32'd14);

        // Extremes
        do_op("ffff_1", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00);
        do_op("ffff_ff", 16'hFFFF, 8'hFF, 16'h0101, 8'h00);

        // Divide by zero
        dividend = 16'h0005;
        divisor  = 8'h00;
        start    = 1'b1;
        step();
        start = 1'b0;
        chk("dz_done", 32'(done), 32'd1);
        chk("dz_busy", 32'(busy), 32'd0);
        chk("dz_q", 32'(q_out), 32'hFFFF);
        chk("dz_r", 32'(r_out), 32'h05);
        chk("dz_flag", 32'(div_zero), 32'd1);

        // done freezes while stalled
        en = 1'b0;
        step();
        step();
        chk("dz_done_frozen", 32'(done), 32'd1);
        en = 1'b1;
        step();
        chk("dz_done_drop", 32'(done), 32'd0);
        chk("dz_flag_hold", 32'(div_zero), 32'd1);

        // 1000 / 3 with a 3-cycle stall mid-run
        dividend = 16'd1000;
        divisor  = 8'd3;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        en   = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (!busy || done || q_out != 16'hFFFF || r_out != 8'h05 || !div_zero) seen = 1'b1;
        end
        chk("stall_frozen", 32'(seen), 32'd0);
        en = 1'b1;
        wait_done(40, n, got);
        chk("stall_done_seen", 32'(got), 32'd1);
        chk("stall_latency", 32'(n + 8), 32'd19);
        chk("stall_q", 32'(q_out), 32'd333);
        chk("stall_r", 32'(r_out), 32'd1);
        step();

        // start while busy is ignored; start on the done edge chains
        dividend = 16'd200;
        divisor  = 8'd9;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        dividend = 16'd9;
        divisor  = 8'd3;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 4; i <= 15; i++) step();
        chk("b2b_busy_pre", 32'(busy), 32'd1);
        dividend = 16'd50000;
        divisor  = 8'd200;
        start    = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_busy1", 32'(busy), 32'd1);
        chk("b2b_q1", 32'(q_out), 32'd22);
        chk("b2b_r1", 32'(r_out), 32'd2);
        seen = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (done || !busy) seen = 1'b1;
        end
        chk("b2b_run2_profile", 32'(seen), 32'd0);
        step();
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_q2", 32'(q_out), 32'd250);
        chk("b2b_r2", 32'(r_out), 32'd0);
        step();

        // Reset in the middle of a run
        dividend = 16'd1234;
        divisor  = 8'd17;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_q", 32'(q_out), 32'd0);
        chk("mrst_r", 32'(r_out), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) seen = 1'b1;
        end
        chk("mrst_no_done", 32'(seen), 32'd0);

        // Randomized operations
        for (int k = 0; k < 1500; k++) run_rand();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
